// File: rtl/puf_ctrl_pkg.sv
// Shared definitions for the PUF challenge/response link: session states and the ID handshake bytes.
// Also used by data_controller, which compares rx bytes against REQUEST_ID and muxes RESPONSE_ID.
package puf_ctrl_pkg;

   localparam logic [7:0] REQUEST_ID  = 8'hAA;
   localparam logic [7:0] RESPONSE_ID = 8'h55;

   typedef enum logic [3:0] {
      S_IDLE,
      S_SEND_ID,
      S_ID_WAIT,
      S_WAIT_CHAL,
      S_EVAL_START,
      S_EVAL_WAIT,
      S_POP,
      S_SEND_BYTE,
      S_BYTE_WAIT
   } session_state_t;

   // States in which the tx mux must point at the response FIFO
   function automatic logic is_resp_phase(input session_state_t s);
      return (s == S_POP) || (s == S_SEND_BYTE) || (s == S_BYTE_WAIT);
   endfunction

endpackage

// File: rtl/puf_wait_timer.sv
// Load/expire down-counter bounding the challenge wait; o_expired is high while enabled at zero.
// Loaded with CYCLES-1 on session entry so expiry falls on the CYCLES-th enabled cycle.
module puf_wait_timer #(
   parameter int CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic i_load,
   input  logic i_en,
   output logic o_expired
);

   localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= W'(CYCLES - 1);
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_expired = i_en && (r_cnt == '0);

endmodule

// File: rtl/puf_session_fsm.sv
// Sequences one PUF session: ID handshake, challenge capture, evaluation, RESP_BYTES FIFO bytes out.
// All outputs registered; CHALLENGE_TIMEOUT_EN adds an abandon-on-silence timer in WAIT_CHAL.
module puf_session_fsm
   import puf_ctrl_pkg::*;
#(
   parameter int RESP_BYTES     = 4,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic rx_valid,
   input  logic id_requested,
   output logic store_challenge,
   output logic puf_start,
   input  logic puf_done,
   input  logic fifo_empty,
   output logic fifo_rd,
   output logic data_sel,
   output logic tx_start,
   input  logic tx_done,
   output logic busy,
   output logic rx_overrun,
   output logic timeout
);

   localparam int               CNT_W     = $clog2(RESP_BYTES + 1);
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(RESP_BYTES - 1);

   session_state_t   r_state;
   session_state_t   w_next;
   logic [CNT_W-1:0] r_byte_cnt;
   logic             r_store, r_puf_start, r_fifo_rd, r_data_sel;
   logic             r_tx_start, r_busy, r_overrun, r_timeout;
   logic             w_store, w_fifo_rd, w_timeout, w_cnt_inc;
   logic             w_overrun_set, w_overrun_clr, w_expired;

`ifdef CHALLENGE_TIMEOUT_EN
   logic w_tmr_load;
   assign w_tmr_load = (r_state == S_ID_WAIT) && tx_done;

   puf_wait_timer #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_tmr_load),
      .i_en      (r_state == S_WAIT_CHAL),
      .o_expired (w_expired)
   );
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
   assign w_expired        = 1'b0;
`endif

   always_comb begin
      w_next        = r_state;
      w_store       = 1'b0;
      w_fifo_rd     = 1'b0;
      w_timeout     = 1'b0;
      w_cnt_inc     = 1'b0;
      w_overrun_clr = 1'b0;
      // Only IDLE and WAIT_CHAL can consume a byte; anything else is lost
      w_overrun_set = rx_valid && (r_state != S_IDLE) && (r_state != S_WAIT_CHAL);
      case (r_state)
         S_IDLE: begin
            if (rx_valid && id_requested) begin
               w_next        = S_SEND_ID;
               w_overrun_clr = 1'b1;
            end
         end
         S_SEND_ID:    w_next = S_ID_WAIT;
         S_ID_WAIT:    if (tx_done) w_next = S_WAIT_CHAL;
         S_WAIT_CHAL: begin
            if (rx_valid) begin
               w_store = 1'b1;
               w_next  = S_EVAL_START;
            end else if (w_expired) begin
               w_timeout = 1'b1;
               w_next    = S_IDLE;
            end
         end
         S_EVAL_START: w_next = S_EVAL_WAIT;
         // A done coinciding with our own start pulse belongs to no evaluation of ours
         S_EVAL_WAIT:  if (puf_done && !r_puf_start) w_next = S_POP;
         S_POP: begin
            if (!fifo_empty) begin
               w_fifo_rd = 1'b1;
               w_next    = S_SEND_BYTE;
            end
         end
         S_SEND_BYTE:  w_next = S_BYTE_WAIT;
         S_BYTE_WAIT: begin
            if (tx_done) begin
               w_cnt_inc = 1'b1;
               w_next    = (r_byte_cnt == LAST_BYTE) ? S_IDLE : S_POP;
            end
         end
         default:      w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_byte_cnt  <= '0;
         r_store     <= 1'b0;
         r_puf_start <= 1'b0;
         r_fifo_rd   <= 1'b0;
         r_data_sel  <= 1'b0;
         r_tx_start  <= 1'b0;
         r_busy      <= 1'b0;
         r_overrun   <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE) begin
            r_byte_cnt <= '0;
         end else if (w_cnt_inc) begin
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
         end
         r_store     <= w_store;
         r_puf_start <= (r_state == S_EVAL_START);
         r_fifo_rd   <= w_fifo_rd;
         r_tx_start  <= (r_state == S_SEND_ID) || (r_state == S_SEND_BYTE);
         // Follows the next state so the mux settles before the matching tx_start
         r_data_sel  <= is_resp_phase(w_next);
         r_busy      <= (w_next != S_IDLE);
         r_timeout   <= w_timeout;
         if (w_overrun_set) begin
            r_overrun <= 1'b1;
         end else if (w_overrun_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign store_challenge = r_store;
   assign puf_start       = r_puf_start;
   assign fifo_rd         = r_fifo_rd;
   assign data_sel        = r_data_sel;
   assign tx_start        = r_tx_start;
   assign busy            = r_busy;
   assign rx_overrun      = r_overrun;
   assign timeout         = r_timeout;

endmodule

// File: tb/tb_puf_session_fsm.sv
// Scenario bench for puf_session_fsm with a FIFO model and a tx-byte scoreboard.
// Build with CHALLENGE_TIMEOUT_EN defined to exercise the challenge timeout.
module tb_puf_session_fsm;
   import puf_ctrl_pkg::*;

   logic clk, reset, rx_valid, id_requested, puf_done, fifo_empty, tx_done;
   logic store_challenge, puf_start, fifo_rd, data_sel, tx_start, busy, rx_overrun, timeout;
   logic [7:0] rx_data;
   logic [7:0] fifo_out;
   logic       hold_empty;

   logic [7:0] fifo_q[$];
   logic [8:0] exp_q[$];
   logic [8:0] obs_q[$];

   int n_chk = 0, n_pass = 0;
   int n_store, n_puf, n_rd, n_tx, n_tmo;

   assign id_requested = (rx_data == REQUEST_ID);

   puf_session_fsm #(.RESP_BYTES(4), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .id_requested(id_requested),
      .store_challenge(store_challenge), .puf_start(puf_start), .puf_done(puf_done),
      .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .data_sel(data_sel), .tx_start(tx_start),
      .tx_done(tx_done), .busy(busy), .rx_overrun(rx_overrun), .timeout(timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: pulse counters, FIFO model pops, and what the UART would actually send
   always @(negedge clk) begin
      if (tx_start === 1'b1) begin
         obs_q.push_back({data_sel, (data_sel ? fifo_out : RESPONSE_ID)});
         n_tx++;
      end
      if (store_challenge === 1'b1) n_store++;
      if (puf_start === 1'b1) n_puf++;
      if (timeout === 1'b1) n_tmo++;
      if (fifo_rd === 1'b1) begin
         n_rd++;
         if (fifo_q.size() > 0) fifo_out = fifo_q.pop_front();
         else fifo_out = 8'hEE;
      end
      fifo_empty = hold_empty || (fifo_q.size() == 0);
   end

   task automatic clr_counts();
      n_store = 0; n_puf = 0; n_rd = 0; n_tx = 0; n_tmo = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      fifo_q.delete();
      hold_empty = 1'b0;
      fifo_empty = 1'b1;
      rx_valid = 1'b0; puf_done = 1'b0; tx_done = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      exp_q.delete();
      obs_q.delete();
      clr_counts();
   endtask

   task automatic pulse_rx(input logic [7:0] b);
      rx_data = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic load_fifo(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         fifo_q.push_back(base + 8'(i));
         exp_q.push_back({1'b1, base + 8'(i)});
      end
      fifo_empty = hold_empty || (fifo_q.size() == 0);
   endtask

   task automatic wait_tx_start();
      int w = 0;
      while (tx_start !== 1'b1 && w < 100) begin @(negedge clk); w++; end
      if (w >= 100) begin
         n_chk++;
         $display("FAIL tx_start_wait: tx_start=%b, required 1 within 100 cycles", tx_start);
      end
   endtask

   task automatic wait_puf_start();
      int w = 0;
      while (puf_start !== 1'b1 && w < 100) begin @(negedge clk); w++; end
      if (w >= 100) begin
         n_chk++;
         $display("FAIL puf_start_wait: puf_start=%b, required 1 within 100 cycles", puf_start);
      end
   endtask

   task automatic serve_tx(input int gap);
      wait_tx_start();
      repeat (gap) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   task automatic to_eval_wait(input logic [7:0] chal);
      pulse_rx(REQUEST_ID);
      serve_tx(2);
      pulse_rx(chal);
      wait_puf_start();
   endtask

   task automatic compare_scoreboard(input string name);
      n_chk++;
      if (obs_q.size() !== exp_q.size())
         $display("FAIL %s_count: %0d tx frames, required %0d", name, obs_q.size(), exp_q.size());
      else n_pass++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         logic [8:0] o, e;
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_chk++;
         if (o !== e) $display("FAIL %s_frame: sel/byte=%h, required %h", name, o, e);
         else n_pass++;
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      logic [7:0] outs;
      reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; puf_done = 1'b0; tx_done = 1'b0;
      hold_empty = 1'b0; fifo_empty = 1'b1; fifo_out = 8'h00;
      clr_counts();
      repeat (3) @(negedge clk);
      outs = {store_challenge, puf_start, fifo_rd, data_sel, tx_start, busy, rx_overrun, timeout};
      n_chk++;
      if (outs !== 8'h00) $display("FAIL reset_outputs: %b, required 00000000", outs); else n_pass++;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      outs = {store_challenge, puf_start, fifo_rd, data_sel, tx_start, busy, rx_overrun, timeout};
      n_chk++;
      if (outs !== 8'h00) $display("FAIL post_reset_idle: %b, required 00000000", outs); else n_pass++;
   endtask

   task automatic test_full_session();
      logic seen;
      clr_counts();
      exp_q.push_back({1'b0, RESPONSE_ID});
      load_fifo(4, 8'hA0);
      pulse_rx(REQUEST_ID);
      n_chk++;
      if (tx_start !== 1'b0) $display("FAIL id_latency_early: tx_start=%b, required 0", tx_start); else n_pass++;
      @(negedge clk);
      n_chk++;
      if (tx_start !== 1'b1) $display("FAIL id_latency: tx_start=%b, required 1", tx_start); else n_pass++;
      serve_tx(3);
      pulse_rx(8'h5C);
      wait_puf_start();
      puf_done = 1'b1;
      @(negedge clk);
      puf_done = 1'b0;
      seen = 1'b0;
      repeat (3) begin @(negedge clk); if (fifo_rd === 1'b1) seen = 1'b1; end
      n_chk++;
      if (seen !== 1'b0) $display("FAIL early_puf_done: fifo_rd seen=%b, required 0", seen); else n_pass++;
      puf_done = 1'b1;
      @(negedge clk);
      puf_done = 1'b0;
      @(negedge clk);
      n_chk++;
      if (fifo_rd !== 1'b1) $display("FAIL pop_latency: fifo_rd=%b, required 1", fifo_rd); else n_pass++;
      @(negedge clk);
      n_chk++;
      if (tx_start !== 1'b1) $display("FAIL byte_latency: tx_start=%b, required 1", tx_start); else n_pass++;
      serve_tx(3);
      repeat (3) serve_tx(2);
      repeat (3) @(negedge clk);
      n_chk++;
      if (n_store !== 1) $display("FAIL full_store: %0d pulses, required 1", n_store); else n_pass++;
      n_chk++;
      if (n_puf !== 1) $display("FAIL full_puf_start: %0d pulses, required 1", n_puf); else n_pass++;
      n_chk++;
      if (n_rd !== 4) $display("FAIL full_fifo_rd: %0d pulses, required 4", n_rd); else n_pass++;
      n_chk++;
      if (n_tx !== 5) $display("FAIL full_tx_start: %0d pulses, required 5", n_tx); else n_pass++;
      n_chk++;
      if (busy !== 1'b0) $display("FAIL full_end_busy: busy=%b, required 0", busy); else n_pass++;
      compare_scoreboard("full");
   endtask

   task automatic test_non_id();
      logic seen_busy;
      clr_counts();
      pulse_rx(8'h12);
      seen_busy = busy;
      repeat (6) begin @(negedge clk); if (busy !== 1'b0) seen_busy = 1'b1; end
      n_chk++;
      if (n_tx !== 0) $display("FAIL non_id_tx: %0d tx_start pulses, required 0", n_tx); else n_pass++;
      n_chk++;
      if (seen_busy !== 1'b0) $display("FAIL non_id_busy: busy seen=%b, required 0", seen_busy); else n_pass++;
      n_chk++;
      if (rx_overrun !== 1'b0) $display("FAIL non_id_overrun: rx_overrun=%b, required 0", rx_overrun); else n_pass++;
   endtask

   task automatic test_chal_is_id();
      clr_counts();
      exp_q.push_back({1'b0, RESPONSE_ID});
      to_eval_wait(REQUEST_ID);
      repeat (4) @(negedge clk);
      n_chk++;
      if (n_store !== 1) $display("FAIL chal_id_store: %0d pulses, required 1", n_store); else n_pass++;
      n_chk++;
      if (n_tx !== 1) $display("FAIL chal_id_no_reply: %0d tx_start pulses, required 1", n_tx); else n_pass++;
      n_chk++;
      if (rx_overrun !== 1'b0) $display("FAIL chal_id_overrun: rx_overrun=%b, required 0", rx_overrun); else n_pass++;
      n_chk++;
      if (busy !== 1'b1) $display("FAIL chal_id_busy: busy=%b, required 1", busy); else n_pass++;
      compare_scoreboard("chal_id");
      do_reset();
   endtask

   task automatic test_fifo_stall();
      logic seen;
      clr_counts();
      exp_q.push_back({1'b0, RESPONSE_ID});
      hold_empty = 1'b1;
      fifo_empty = 1'b1;
      to_eval_wait(8'h99);
      @(negedge clk);
      puf_done = 1'b1;
      @(negedge clk);
      puf_done = 1'b0;
      seen = 1'b0;
      repeat (10) begin @(negedge clk); if (fifo_rd === 1'b1) seen = 1'b1; end
      n_chk++;
      if (seen !== 1'b0) $display("FAIL stall_withheld: fifo_rd seen=%b, required 0", seen); else n_pass++;
      hold_empty = 1'b0;
      load_fifo(4, 8'hD0);
      @(negedge clk);
      n_chk++;
      if (fifo_rd !== 1'b1) $display("FAIL stall_release: fifo_rd=%b, required 1", fifo_rd); else n_pass++;
      repeat (4) serve_tx(2);
      repeat (3) @(negedge clk);
      n_chk++;
      if (n_rd !== 4) $display("FAIL stall_fifo_rd: %0d pulses, required 4", n_rd); else n_pass++;
      n_chk++;
      if (busy !== 1'b0) $display("FAIL stall_end_busy: busy=%b, required 0", busy); else n_pass++;
      compare_scoreboard("stall");
   endtask

   task automatic test_overrun();
      clr_counts();
      exp_q.push_back({1'b0, RESPONSE_ID});
      load_fifo(4, 8'hC0);
      to_eval_wait(8'h3C);
      @(negedge clk);
      puf_done = 1'b1;
      @(negedge clk);
      puf_done = 1'b0;
      wait_tx_start();
      repeat (2) @(negedge clk);
      tx_done = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
      @(negedge clk);
      tx_done = 1'b0; rx_valid = 1'b0;
      n_chk++;
      if (rx_overrun !== 1'b1) $display("FAIL overrun_set: rx_overrun=%b, required 1", rx_overrun); else n_pass++;
      repeat (3) serve_tx(2);
      repeat (3) @(negedge clk);
      n_chk++;
      if (n_rd !== 4) $display("FAIL overrun_byte_cnt: %0d pops, required 4", n_rd); else n_pass++;
      n_chk++;
      if (busy !== 1'b0) $display("FAIL overrun_end_busy: busy=%b, required 0", busy); else n_pass++;
      n_chk++;
      if (rx_overrun !== 1'b1) $display("FAIL overrun_sticky: rx_overrun=%b, required 1", rx_overrun); else n_pass++;
      exp_q.push_back({1'b0, RESPONSE_ID});
      pulse_rx(REQUEST_ID);
      n_chk++;
      if (rx_overrun !== 1'b0) $display("FAIL overrun_clear: rx_overrun=%b, required 0", rx_overrun); else n_pass++;
      serve_tx(2);
      compare_scoreboard("overrun");
      do_reset();
   endtask

   task automatic test_timeout();
      logic seen;
      clr_counts();
      pulse_rx(REQUEST_ID);
      serve_tx(2);
      seen = 1'b0;
`ifdef CHALLENGE_TIMEOUT_EN
      for (int k = 2; k <= 17; k++) begin
         @(negedge clk);
         if (k == 16) begin
            n_chk++;
            if (timeout !== 1'b0) $display("FAIL timeout_early: timeout=%b, required 0", timeout); else n_pass++;
         end
      end
      n_chk++;
      if (timeout !== 1'b1) $display("FAIL timeout_pulse: timeout=%b, required 1", timeout); else n_pass++;
      n_chk++;
      if (busy !== 1'b0) $display("FAIL timeout_idle: busy=%b, required 0", busy); else n_pass++;
      repeat (3) @(negedge clk);
      n_chk++;
      if (n_tmo !== 1) $display("FAIL timeout_count: %0d pulses, required 1", n_tmo); else n_pass++;
`else
      repeat (40) begin @(negedge clk); if (timeout !== 1'b0) seen = 1'b1; end
      n_chk++;
      if (seen !== 1'b0) $display("FAIL no_timeout: timeout seen=%b, required 0", seen); else n_pass++;
      n_chk++;
      if (busy !== 1'b1) $display("FAIL wait_forever: busy=%b, required 1", busy); else n_pass++;
`endif
      n_chk++;
      if (n_store !== 0) $display("FAIL timeout_store: %0d pulses, required 0", n_store); else n_pass++;
      do_reset();
   endtask

   task automatic test_reset_mid();
      logic [7:0] outs;
      clr_counts();
      to_eval_wait(8'h42);
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b1) $display("FAIL mid_busy: busy=%b, required 1", busy); else n_pass++;
      reset = 1'b0;
      #1;
      outs = {store_challenge, puf_start, fifo_rd, data_sel, tx_start, busy, rx_overrun, timeout};
      n_chk++;
      if (outs !== 8'h00) $display("FAIL mid_reset_outputs: %b, required 00000000", outs); else n_pass++;
      do_reset();
   endtask

   initial begin
      test_reset();
      test_full_session();
      test_non_id();
      test_chal_is_id();
      test_fifo_stall();
      test_overrun();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
